imem_fetch_responder: RTL
=========================

Name: imem_fetch_responder

Overview:
- Instruction-memory responder at the far end of the core's fetch interface: takes a 64-bit PC request from the fetch unit and returns the 32-bit instruction word.
- Word-organised storage, filled through a loader write port; configurable read latency; one outstanding request; valid/ready handshake on both request and response channels.
- Sits beside the core top and replaces a direct combinational instruction feed, so multi-cycle fetch can be exercised.

Parameters:
- BASE_ADDR, 64'h0000_0000_8000_0000, byte address of word 0.
- DEPTH_LOG2, 12, log2 of the word count (4096 words = 16 KiB).
- LATENCY, 1, cycles from request accept to rsp_valid; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  fetch request present.
- req_ready  out  1  responder can accept a request.
- req_pc  in  64  byte address of the instruction.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  fetch unit accepts the response.
- rsp_inst  out  32  instruction word; 32'h0000_0013 (nop) on error.
- rsp_err  out  1  1 = misaligned or out-of-range PC.
- load_en  in  1  loader write strobe.
- load_addr  in  DEPTH_LOG2  word index to write.
- load_data  in  32  word to write.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_inst=32'h0000_0013, rsp_err=0, FSM=IDLE, latency counter=0. Storage contents are not reset.
- Reset is asynchronous and takes effect mid-transaction. Any in-flight request is dropped, and no response follows reset release.
- FSM states and transitions:
  - IDLE: req_ready=1. A request is accepted when req_valid && req_ready. On accept, latch req_pc and load counter with LATENCY-1. Go to WAIT if LATENCY>1, otherwise go to RESP.
  - WAIT: req_ready=0. Counter decrements each cycle. At 0, go to RESP.
  - RESP: rsp_valid=1. rsp_inst and rsp_err are stable until the handshake. When rsp_valid && rsp_ready, go to IDLE. req_ready is 0 in RESP; there is no back-to-back overlap.
- Timing: with LATENCY=1, a request accepted on edge N shows rsp_valid high after edge N+1.
- Word index = (pc - BASE_ADDR) >> 2, computed with 64-bit unsigned wrap.
- Error conditions: pc[1:0] != 0, or pc < BASE_ADDR, or index >= 2^DEPTH_LOG2.
  - On error: rsp_err=1 and rsp_inst=nop; no storage access.
  - Misaligned takes precedence; the result is the same either way.
- Storage is a synchronous-read array. The read is issued in the cycle that enters RESP, or earlier, as long as data is valid by RESP.
- Loader writes occur on the clock edge when load_en=1, in any state.
- Write/read collision (same word written in the cycle the read samples): the response returns the new data (write-first).
- A request arriving while the block is not in IDLE is not accepted. The requester must hold req_valid and req_pc until the accept.

Decomposition:
- Shared package holds:
  - NOP_INST = 32'h0000_0013.
  - Default BASE_ADDR.
  - FSM state typedef (IDLE, WAIT, RESP).
  - Response struct {inst, err}.
- One sub-module: imem_sram_1r1w, a DEPTH_LOG2-addressed 32-bit array with a write-first synchronous read. The FSM, counter and address check live in the top.

Test Plan:
- Load word 0 = 32'h0010_0093. With LATENCY=1, send req_pc=64'h8000_0000 and hold rsp_ready=1 -> rsp_valid one cycle after accept, rsp_inst=32'h0010_0093, rsp_err=0, back in IDLE next cycle.
- With LATENCY=4, request pc=64'h8000_0004 (loaded 32'hFFF0_0113) -> rsp_valid exactly 4 cycles after accept, req_ready low throughout.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_inst stable, req_ready=0, new req_valid ignored. Raise rsp_ready -> handshake completes, next request is accepted the following cycle.
- req_pc=64'h8000_0002 -> rsp_err=1, rsp_inst=32'h0000_0013. req_pc=64'h7FFF_FFFC and req_pc=64'h8000_4000 (DEPTH_LOG2=12) -> rsp_err=1, rsp_inst=nop.
- Assert rst during WAIT -> outputs return to reset values immediately (asynchronous); after release there is no response, and req_ready=1 from the first cycle after release.
- load_en writes 32'hDEAD_BEEF to index 3 in the same cycle the read of pc=64'h8000_000C samples -> rsp_inst=32'hDEAD_BEEF.

Source files
------------

// File: rtl/imem_fetch_responder_pkg.sv
// Shared definitions for the instruction-memory fetch responder.
//   NOP_INST      : word returned with an error response (addi x0,x0,0)
//   DEF_BASE_ADDR : default byte address of word 0
//   state_t       : responder FSM states
//   rsp_t         : response payload {inst, err}
package imem_fetch_responder_pkg;

    localparam logic [31:0] NOP_INST      = 32'h0000_0013;
    localparam logic [63:0] DEF_BASE_ADDR = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } rsp_t;

endpackage

// File: rtl/imem_sram_1r1w.sv
// 32-bit word array, one write port and one synchronous read port.
// A read that samples the word being written in the same edge returns the
// new data (write-first). Contents and read register are not reset.
//   clk     : clock
//   i_we    : write strobe       i_waddr / i_wdata : write word index / data
//   i_re    : read strobe        i_raddr           : read word index
//   o_rdata : read data, held until the next read strobe
module imem_sram_1r1w #(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [31:0]           i_wdata,
    input  logic                  i_re,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [31:0]           o_rdata
);

    logic [31:0] r_mem [0:(2**DEPTH_LOG2)-1];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
        if (i_re)
            r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder for the core fetch port. Accepts one 64-bit
// PC request at a time, returns the 32-bit instruction LATENCY cycles after
// the accept edge, flags misaligned / out-of-range PCs with err + nop.
//   clk, rst                      : clock, async active-high reset
//   req_valid/req_ready/req_pc    : fetch request channel
//   rsp_valid/rsp_ready           : response handshake
//   rsp_inst/rsp_err              : response payload
//   load_en/load_addr/load_data   : loader write port (any state)
module imem_fetch_responder
    import imem_fetch_responder_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR  = DEF_BASE_ADDR,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [63:0]           req_pc,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_inst,
    output logic                  rsp_err,
    input  logic                  load_en,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [31:0]           load_data
);

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic                  r_err;
    logic                  r_req_ready;
    logic                  r_rsp_valid;

    logic [61:0]           w_word;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_err;
    logic                  w_rd_en;
    logic [31:0]           w_rdata;
    rsp_t                  w_rsp;

    // Word offset from the base with 64-bit wrap; a PC below the base wraps
    // to a huge offset, but the explicit compare keeps the intent readable.
    assign w_word = 62'((req_pc - BASE_ADDR) >> 2);
    assign w_idx  = w_word[DEPTH_LOG2-1:0];
    assign w_err  = (req_pc[1:0] != 2'b00) || (req_pc < BASE_ADDR) ||
                    ((w_word >> DEPTH_LOG2) != 62'd0);

    // Every accept passes through WAIT (at least one cycle), so the response
    // appears LATENCY edges after the accept edge. The array read fires on
    // the last WAIT edge, which is also the edge that enters RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_idx       <= '0;
            r_err       <= 1'b0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (req_valid && r_req_ready) begin
                        r_idx       <= w_idx;
                        r_err       <= w_err;
                        r_cnt       <= LAT_M1;
                        r_req_ready <= 1'b0;
                        r_state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Errored requests never touch the array.
    assign w_rd_en = (r_state == ST_WAIT) && (r_cnt == 4'd0) && !r_err;

    imem_sram_1r1w #(.DEPTH_LOG2(DEPTH_LOG2)) u_sram (
        .clk     (clk),
        .i_we    (load_en),
        .i_waddr (load_addr),
        .i_wdata (load_data),
        .i_re    (w_rd_en),
        .i_raddr (r_idx),
        .o_rdata (w_rdata)
    );

    // Read data is held by the array until the next read, so the payload is
    // stable through a stalled RESP; outside RESP the bus shows nop.
    assign w_rsp.inst = (r_rsp_valid && !r_err) ? w_rdata : NOP_INST;
    assign w_rsp.err  = r_rsp_valid && r_err;

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_inst  = w_rsp.inst;
    assign rsp_err   = w_rsp.err;

endmodule
